// File: rtl/line_pkg.sv
// Shared types and default sizes for the Bresenham line rasterizer.
package line_pkg;

    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;
    localparam int DEF_X_W   = 10;
    localparam int DEF_Y_W   = 9;
    localparam int DEF_ERR_W = ((DEF_X_W > DEF_Y_W) ? DEF_X_W : DEF_Y_W) + 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_DRAW  = 2'd2
    } state_t;

endpackage

// File: rtl/line_step.sv
// One Bresenham step: next position and error term, plus end-point detection.
module line_step #(
    parameter int X_W   = line_pkg::DEF_X_W,
    parameter int Y_W   = line_pkg::DEF_Y_W,
    parameter int ERR_W = line_pkg::DEF_ERR_W
) (
    input  logic                    i_sx_neg,
    input  logic                    i_sy_neg,
    input  logic        [X_W-1:0]   i_x,
    input  logic        [Y_W-1:0]   i_y,
    input  logic        [X_W-1:0]   i_x1,
    input  logic        [Y_W-1:0]   i_y1,
    input  logic signed [ERR_W-1:0] i_err,
    input  logic signed [ERR_W-1:0] i_dx,
    input  logic signed [ERR_W-1:0] i_dy,
    output logic        [X_W-1:0]   o_x,
    output logic        [Y_W-1:0]   o_y,
    output logic signed [ERR_W-1:0] o_err,
    output logic                    o_at_end
);
    logic signed [ERR_W-1:0] w_e2;
    logic                    w_step_x;
    logic                    w_step_y;

    // Both decisions use the same e2, so diagonal steps update x and y together.
    assign w_e2     = i_err <<< 1;
    assign w_step_x = (w_e2 >= i_dy);
    assign w_step_y = (w_e2 <= i_dx);

    assign o_x = !w_step_x ? i_x : (i_sx_neg ? i_x - X_W'(1) : i_x + X_W'(1));
    assign o_y = !w_step_y ? i_y : (i_sy_neg ? i_y - Y_W'(1) : i_y + Y_W'(1));

    assign o_err    = i_err + (w_step_x ? i_dy : '0) + (w_step_y ? i_dx : '0);
    assign o_at_end = (o_x == i_x1) && (o_y == i_y1);

endmodule

// File: rtl/line_rasterizer.sv
// Latches a line request and emits one Bresenham pixel per clock toward the frame buffer.
module line_rasterizer
    import line_pkg::*;
#(
    parameter int H_RES = DEF_H_RES,
    parameter int V_RES = DEF_V_RES,
    parameter int X_W   = DEF_X_W,
    parameter int Y_W   = DEF_Y_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           set,
    input  logic [X_W-1:0] x0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y0,
    input  logic [Y_W-1:0] y1,
    input  logic           colour_in,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           colour,
    output logic           pixel_valid,
    output logic           busy,
    output logic           done
);
    localparam int ERR_W = ((X_W > Y_W) ? X_W : Y_W) + 3;

    state_t                  r_state;
    logic        [X_W-1:0]   r_x0, r_x1, r_x;
    logic        [Y_W-1:0]   r_y0, r_y1, r_y;
    logic signed [ERR_W-1:0] r_dx, r_dy, r_err;
    logic                    r_sx_neg, r_sy_neg;
    logic                    r_colour, r_pv, r_busy, r_done;

    logic        [X_W-1:0]   w_adx, w_nx;
    logic        [Y_W-1:0]   w_ady, w_ny;
    logic signed [ERR_W-1:0] w_dx, w_dy, w_nerr;
    logic                    w_sx_neg, w_sy_neg, w_at_end;

    function automatic logic in_range(input logic [X_W-1:0] px, input logic [Y_W-1:0] py);
        return (int'(px) < H_RES) && (int'(py) < V_RES);
    endfunction

    assign w_sx_neg = (r_x1 < r_x0);
    assign w_sy_neg = (r_y1 < r_y0);
    assign w_adx    = w_sx_neg ? (r_x0 - r_x1) : (r_x1 - r_x0);
    assign w_ady    = w_sy_neg ? (r_y0 - r_y1) : (r_y1 - r_y0);
    assign w_dx     = $signed({{(ERR_W-X_W){1'b0}}, w_adx});
    assign w_dy     = -$signed({{(ERR_W-Y_W){1'b0}}, w_ady});

    line_step #(.X_W(X_W), .Y_W(Y_W), .ERR_W(ERR_W)) u_step (
        .i_sx_neg (r_sx_neg),
        .i_sy_neg (r_sy_neg),
        .i_x      (r_x),
        .i_y      (r_y),
        .i_x1     (r_x1),
        .i_y1     (r_y1),
        .i_err    (r_err),
        .i_dx     (r_dx),
        .i_dy     (r_dy),
        .o_x      (w_nx),
        .o_y      (w_ny),
        .o_err    (w_nerr),
        .o_at_end (w_at_end)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_x0     <= '0;
            r_x1     <= '0;
            r_y0     <= '0;
            r_y1     <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_colour <= 1'b0;
            r_pv     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (set) begin
                        r_x0     <= x0;
                        r_x1     <= x1;
                        r_y0     <= y0;
                        r_y1     <= y1;
                        r_colour <= colour_in;
                        r_busy   <= 1'b1;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_dx     <= w_dx;
                    r_dy     <= w_dy;
                    r_err    <= w_dx + w_dy;
                    r_sx_neg <= w_sx_neg;
                    r_sy_neg <= w_sy_neg;
                    r_x      <= r_x0;
                    r_y      <= r_y0;
                    r_pv     <= in_range(r_x0, r_y0);
                    r_done   <= (r_x0 == r_x1) && (r_y0 == r_y1);
                    r_state  <= S_DRAW;
                end
                S_DRAW: begin
                    // r_done marks that the end pixel is already on the outputs.
                    if (r_done) begin
                        r_pv    <= 1'b0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_x    <= w_nx;
                        r_y    <= w_ny;
                        r_err  <= w_nerr;
                        r_pv   <= in_range(w_nx, w_ny);
                        r_done <= w_at_end;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign colour      = r_colour;
    assign pixel_valid = r_pv;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_line_rasterizer.sv
// Scoreboard bench for line_rasterizer: a Bresenham model queues expected pixels, a monitor checks them.
module tb_line_rasterizer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       set = 1'b0;
    logic [9:0] tx0 = '0, tx1 = '0;
    logic [8:0] ty0 = '0, ty1 = '0;
    logic       tcol = 1'b0;
    logic [9:0] x;
    logic [8:0] y;
    logic       colour, pixel_valid, busy, done;

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        logic       col;
        logic       pv;
        logic       dn;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;
    int   last_x = -1;
    int   last_y = -1;

    line_rasterizer dut (
        .clk         (clk),
        .reset       (reset),
        .set         (set),
        .x0          (tx0),
        .x1          (tx1),
        .y0          (ty0),
        .y1          (ty1),
        .colour_in   (tcol),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .pixel_valid (pixel_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic void chk(input bit ok, input string name, input string act, input string req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", name, act, req);
        end
    endfunction

    // Reference Bresenham; queues only cycles where the DUT shows pixel_valid or done.
    task automatic push_line(input int ax0, input int ay0, input int ax1, input int ay1, input bit col);
        int dx, dy, sx, sy, err, e2, cx, cy;
        bit last, pv;
        exp_t e;
        dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        dy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
        sx  = (ax0 < ax1) ? 1 : -1;
        sy  = (ay0 < ay1) ? 1 : -1;
        err = dx + dy;
        cx  = ax0;
        cy  = ay0;
        forever begin
            last = (cx == ax1) && (cy == ay1);
            pv   = (cx < 640) && (cy < 480);
            if (pv || last) begin
                e.x = 10'(cx); e.y = 9'(cy); e.col = col; e.pv = pv; e.dn = last;
                q.push_back(e);
            end
            if (last) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; cx += sx; end
            if (e2 <= dx) begin err += dx; cy += sy; end
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && (pixel_valid || done)) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_pixel", $sformatf("(%0d,%0d) dn=%0b", x, y, done), "no output");
                end else begin
                    e = q.pop_front();
                    pops++;
                    last_x = int'(x);
                    last_y = int'(y);
                    chk(x == e.x && y == e.y && colour == e.col && pixel_valid == e.pv && done == e.dn,
                        "pixel",
                        $sformatf("(%0d,%0d) c=%0b pv=%0b dn=%0b", x, y, colour, pixel_valid, done),
                        $sformatf("(%0d,%0d) c=%0b pv=%0b dn=%0b", e.x, e.y, e.col, e.pv, e.dn));
                end
            end
        end
    end

    task automatic issue(input int ax0, input int ay0, input int ax1, input int ay1, input bit col, input bit push);
        @(negedge clk);
        tx0 = 10'(ax0); ty0 = 9'(ay0); tx1 = 10'(ax1); ty1 = 9'(ay1); tcol = col;
        set = 1'b1;
        if (push) push_line(ax0, ay0, ax1, ay1, col);
        @(posedge clk);
        #1 set = 1'b0;
    endtask

    // Called 1 time unit after the set edge; busy must fall exactly N+1 edges later.
    task automatic wait_idle(input string name, input int n, input int ax0, input int ay0);
        int cyc = 0;
        chk(busy == 1'b1 && pixel_valid == 1'b0, {name, "_setup"},
            $sformatf("busy=%0b pv=%0b", busy, pixel_valid), "busy=1 pv=0");
        while (busy && cyc < 5000) begin
            @(posedge clk);
            #1 cyc++;
            if (cyc == 1)
                chk(int'(x) == ax0 && int'(y) == ay0, {name, "_first"},
                    $sformatf("(%0d,%0d)", x, y), $sformatf("(%0d,%0d)", ax0, ay0));
        end
        chk(cyc == n + 1, {name, "_busy_len"}, $sformatf("%0d", cyc), $sformatf("%0d", n + 1));
        chk(q.size() == 0, {name, "_drained"}, $sformatf("%0d left", q.size()), "0 left");
    endtask

    initial begin
        int n, p0;
        repeat (2) @(negedge clk);
        chk(busy == 0 && pixel_valid == 0 && done == 0 && x == 0 && y == 0 && colour == 0, "reset_state",
            $sformatf("b=%0b pv=%0b d=%0b x=%0d y=%0d c=%0b", busy, pixel_valid, done, x, y, colour), "all 0");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        issue(0, 0, 639, 0, 1'b0, 1'b1);
        wait_idle("hline", 640, 0, 0);
        chk(last_x == 639 && last_y == 0, "hline_last", $sformatf("(%0d,%0d)", last_x, last_y), "(639,0)");

        p0 = pops;
        issue(5, 5, 5, 5, 1'b1, 1'b1);
        wait_idle("point", 1, 5, 5);
        chk(pops - p0 == 1, "point_count", $sformatf("%0d", pops - p0), "1");

        p0 = pops;
        issue(10, 20, 7, 5, 1'b1, 1'b1);
        wait_idle("steep", 16, 10, 20);
        chk(pops - p0 == 16, "steep_count", $sformatf("%0d", pops - p0), "16");
        chk(last_x == 7 && last_y == 5, "steep_last", $sformatf("(%0d,%0d)", last_x, last_y), "(7,5)");

        p0 = pops;
        issue(0, 0, 3, 3, 1'b1, 1'b1);
        wait_idle("diag", 4, 0, 0);
        chk(pops - p0 == 4 && last_x == 3 && last_y == 3, "diag_end",
            $sformatf("n=%0d (%0d,%0d)", pops - p0, last_x, last_y), "n=4 (3,3)");

        p0 = pops;
        issue(630, 470, 650, 470, 1'b1, 1'b1);
        wait_idle("clip", 21, 630, 470);
        chk(pops - p0 == 11 && last_x == 650, "clip_outputs",
            $sformatf("n=%0d last_x=%0d", pops - p0, last_x), "n=11 last_x=650");

        // A request during the line and one on its done cycle must both be dropped.
        issue(0, 0, 9, 0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        tx0 = 10'd100; ty0 = 9'd100; tx1 = 10'd120; ty1 = 9'd100; set = 1'b1;
        @(negedge clk);
        set = 1'b0;
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        chk(done == 1'b1, "done_seen", $sformatf("%0b", done), "1");
        tx0 = 10'd200; ty0 = 9'd10; tx1 = 10'd210; ty1 = 9'd10; set = 1'b1;
        @(negedge clk);
        set = 1'b0;
        chk(busy == 1'b0, "done_set_ignored", $sformatf("busy=%0b", busy), "busy=0");
        chk(q.size() == 0, "one_line_only", $sformatf("%0d left", q.size()), "0 left");
        issue(3, 7, 0, 4, 1'b0, 1'b1);
        wait_idle("after_busy", 4, 3, 7);

        issue(0, 0, 300, 50, 1'b1, 1'b1);
        n = 0;
        while (!(pixel_valid && x == 10'd100) && n < 500) begin @(negedge clk); n++; end
        chk(pixel_valid && x == 10'd100, "reached_px100", $sformatf("x=%0d", x), "x=100");
        #2 reset = 1'b0;
        #1;
        chk(busy == 0 && pixel_valid == 0 && done == 0 && x == 0 && y == 0, "midline_reset",
            $sformatf("b=%0b pv=%0b d=%0b x=%0d y=%0d", busy, pixel_valid, done, x, y), "all 0");
        q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk(busy == 0 && pixel_valid == 0, "stays_idle", $sformatf("b=%0b pv=%0b", busy, pixel_valid), "0 0");
        issue(2, 3, 40, 17, 1'b0, 1'b1);
        wait_idle("post_reset", 39, 2, 3);
        chk(last_x == 40 && last_y == 17, "post_reset_last", $sformatf("(%0d,%0d)", last_x, last_y), "(40,17)");

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
